// File: rtl/pll_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_seq_pkg
// Purpose  : Shared types, widths and helpers for the PLL lock sequencer.
//            seq_state_t - sequencer states PLL_RST / WAIT_LOCK / STABLE / RUN
//            SEL_W       - width of the rPLL divider selects
//            STAT_W      - width of the saturating statistic counters
// Revision : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

  localparam int SEL_W  = 6;
  localparam int STAT_W = 8;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  // Larger of two unsigned values; used to size the shared phase counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Saturating increment for the statistic counters (sticks at all-ones).
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Generic two-flop synchroniser with synchronous active-high clear.
// Ports    : clk  in          destination clock
//            rst  in          synchronous clear, forces both stages to 0
//            d    in  WIDTH   asynchronous input
//            q    out WIDTH   synchronised output (two-cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  assign q = sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_sequencer
// Purpose  : Power-up sequencer for the rPLL. Holds the PLL in reset, waits
//            for LOCK, qualifies lock stability, then releases the system
//            reset for PLL-clocked logic. Restarts on lock loss or on a
//            software divider reconfiguration. Runs on the crystal clock.
// Ports    : CLKIN        in   1  crystal clock, sole clock of this block
//            RESET        in   1  synchronous active-high reset
//            pll_lock     in   1  rPLL LOCK (asynchronous)
//            pll_reset    out  1  rPLL RESET
//            pll_idsel    out  6  rPLL IDSEL
//            pll_fbdsel   out  6  rPLL FBDSEL
//            pll_odsel    out  6  rPLL ODSEL
//            sys_rst      out  1  reset for PLL-clocked logic
//            ready        out  1  high only in RUN
//            cfg_valid    in   1  reconfiguration request
//            cfg_ready    out  1  equals ready
//            cfg_idsel    in   6  new IDSEL
//            cfg_fbdsel   in   6  new FBDSEL
//            cfg_odsel    in   6  new ODSEL
//            timeout_cnt  out  8  WAIT_LOCK timeouts, saturating
//            loss_cnt     out  8  lock-loss events in RUN, saturating
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned      RST_CYCLES    = 16,
  parameter int unsigned      LOCK_TIMEOUT  = 65536,
  parameter int unsigned      STABLE_CYCLES = 1024,
  parameter int unsigned      LOSS_FILTER   = 4,
  parameter logic [SEL_W-1:0] DEF_IDSEL     = 6'd0,
  parameter logic [SEL_W-1:0] DEF_FBDSEL    = 6'd0,
  parameter logic [SEL_W-1:0] DEF_ODSEL     = 6'd0
) (
  input  logic              CLKIN,
  input  logic              RESET,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic [SEL_W-1:0]  pll_idsel,
  output logic [SEL_W-1:0]  pll_fbdsel,
  output logic [SEL_W-1:0]  pll_odsel,
  output logic              sys_rst,
  output logic              ready,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [SEL_W-1:0]  cfg_idsel,
  input  logic [SEL_W-1:0]  cfg_fbdsel,
  input  logic [SEL_W-1:0]  cfg_odsel,
  output logic [STAT_W-1:0] timeout_cnt,
  output logic [STAT_W-1:0] loss_cnt
);

  // Shared phase counter sized for the longest terminal count of any state.
  localparam int unsigned CNT_MAX = max_u(max_u(RST_CYCLES - 1, LOCK_TIMEOUT - 1),
                                          max_u(STABLE_CYCLES - 1, LOSS_FILTER - 1));
  localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);

  seq_state_t        state;
  seq_state_t        state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              timeout_hit;
  logic              loss_hit;
  logic              cfg_take;

  logic              lock_s;
  logic              sync_clr;

  logic              pll_reset_q;
  logic              sys_rst_q;
  logic              ready_q;
  logic [SEL_W-1:0]  idsel_q;
  logic [SEL_W-1:0]  fbdsel_q;
  logic [SEL_W-1:0]  odsel_q;
  logic [STAT_W-1:0] timeout_q;
  logic [STAT_W-1:0] loss_q;

  // LOCK is meaningless while the PLL is held in reset, so the synchroniser
  // is flushed for that whole interval. This keeps a stale lock from a
  // previous attempt from short-cutting WAIT_LOCK, and makes the sync lag
  // part of the minimum latency after every PLL reset.
  assign sync_clr = RESET | pll_reset_q;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk (CLKIN),
    .rst (sync_clr),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state <= PLL_RST;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and event decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next  = state;
    cnt_next    = cnt + 1'b1;
    timeout_hit = 1'b0;
    loss_hit    = 1'b0;
    cfg_take    = 1'b0;

    case (state)
      PLL_RST: begin
        if (cnt == RST_LAST) begin
          state_next = WAIT_LOCK;
        end
      end

      WAIT_LOCK: begin
        // Lock seen on the last timeout cycle still wins.
        if (lock_s) begin
          state_next = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next  = PLL_RST;
          timeout_hit = 1'b1;
        end
      end

      STABLE: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_next = RUN;
        end
      end

      RUN: begin
        // In RUN the counter is the lock-loss filter: it counts consecutive
        // low samples and any high sample clears it.
        if (lock_s) begin
          cnt_next = '0;
        end
        // A reconfiguration restarts the PLL anyway, so a coincident lock
        // loss is not counted.
        if (cfg_valid) begin
          cfg_take   = 1'b1;
          state_next = PLL_RST;
        end else if (!lock_s && (cnt == LOSS_LAST)) begin
          loss_hit   = 1'b1;
          state_next = PLL_RST;
        end
      end

      default: begin
        state_next = PLL_RST;
      end
    endcase

    if (state_next != state) begin
      cnt_next = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so that they change on
  // the very edge that enters a state (sys_rst drops on the edge into RUN,
  // pll_reset and the new selects appear together on the transfer edge).
  // --------------------------------------------------------------------------
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      pll_reset_q <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      idsel_q     <= DEF_IDSEL;
      fbdsel_q    <= DEF_FBDSEL;
      odsel_q     <= DEF_ODSEL;
      timeout_q   <= '0;
      loss_q      <= '0;
    end else begin
      pll_reset_q <= (state_next == PLL_RST);
      sys_rst_q   <= (state_next != RUN);
      ready_q     <= (state_next == RUN);
      if (cfg_take) begin
        idsel_q  <= cfg_idsel;
        fbdsel_q <= cfg_fbdsel;
        odsel_q  <= cfg_odsel;
      end
      if (timeout_hit) begin
        timeout_q <= sat_inc(timeout_q);
      end
      if (loss_hit) begin
        loss_q <= sat_inc(loss_q);
      end
    end
  end

  assign pll_reset   = pll_reset_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign cfg_ready   = ready_q;
  assign pll_idsel   = idsel_q;
  assign pll_fbdsel  = fbdsel_q;
  assign pll_odsel   = odsel_q;
  assign timeout_cnt = timeout_q;
  assign loss_cnt    = loss_q;

endmodule
`default_nettype wire
